reg_dump_reader: RTL



---
 rtl/reg_dump_reader.sv | 89 ++++++++
 1 files changed

// File: rtl/reg_dump_reader.sv
// Debug read-out engine: sweeps every architectural register through one register-file read port
// and streams the captured values out over a valid/ready handshake. It never writes the file.
module reg_dump_reader #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_idx,
  output logic              dump_last
);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StSend,
    StDone
  } state_e;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              handshake;

  assign handshake = dump_valid & dump_ready;

  // Beat registers are loaded only in StRead, so later register-file writes never reach a beat
  // that is already on offer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_idx   <= '0;
      dump_last  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            idx_q   <= '0;
            state_q <= StRead;
          end
        end
        StRead: begin
          dump_data  <= rd_data;
          dump_idx   <= idx_q;
          dump_last  <= (idx_q == LastIdx);
          dump_valid <= 1'b1;
          state_q    <= StSend;
        end
        StSend: begin
          if (handshake) begin
            dump_valid <= 1'b0;
            if (idx_q == LastIdx) begin
              dump_last <= 1'b0;
              state_q   <= StDone;
            end else begin
              idx_q   <= idx_q + ADDR_W'(1);
              state_q <= StRead;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Remaining outputs decode straight from state/idx; nothing depends on start or dump_ready.
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign rd_addr = (state_q == StIdle) ? '0 : idx_q;

endmodule
